// File: rtl/ov_fifo_reader.sv
// Reads one RGB565 frame out of an AL422 FIFO for one of two arbitrated consumers,
// then hands the FIFO back to the write side through the frame_read handshake.
module ov_fifo_reader #(
   parameter int H_PIX     = 320,
   parameter int V_LINES   = 240,
   parameter int RRST_CLKS = 2
) (
   input  logic        clk_25MHz,
   input  logic        rst_n,
   input  logic        new_frame,
   output logic        frame_read,
   output logic        rrst,
   output logic        oe,
   output logic        rclk,
   input  logic [7:0]  fifo_d,
   input  logic [1:0]  req,
   output logic [1:0]  grant,
   output logic [15:0] pixel,
   output logic        pix_valid,
   output logic [8:0]  pix_x,
   output logic [7:0]  pix_y,
   output logic        frame_done
);
   typedef enum logic [1:0] {IDLE, RRST, READ, DONE} state_t;

   localparam int RCW = $clog2(2*RRST_CLKS + 1);
   localparam logic [RCW-1:0] RC_LAST = RCW'(2*RRST_CLKS - 1);
   localparam logic [8:0] LAST_X = 9'(H_PIX - 1);
   localparam logic [7:0] LAST_Y = 8'(V_LINES - 1);

   state_t         state;
   logic           last_gnt;
   logic [RCW-1:0] rst_cnt;
   logic [1:0]     phase;
   logic [7:0]     hi_byte;
   logic [8:0]     nx;
   logic [7:0]     ny;
   logic           last_px;
   logic [1:0]     req_pick;
   logic           owner_lost;
   logic           at_last;

   always_comb begin
      req_pick = req;
      if (req == 2'b11)
         req_pick = last_gnt ? 2'b01 : 2'b10;
   end

   assign owner_lost = (req & grant) == 2'b00;
   assign at_last    = (nx == LAST_X) && (ny == LAST_Y);

   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_gnt   <= 1'b1;
         rst_cnt    <= '0;
         phase      <= '0;
         hi_byte    <= '0;
         nx         <= '0;
         ny         <= '0;
         last_px    <= 1'b0;
         frame_read <= 1'b1;
         rrst       <= 1'b1;
         oe         <= 1'b1;
         rclk       <= 1'b0;
         grant      <= 2'b00;
         pixel      <= '0;
         pix_valid  <= 1'b0;
         pix_x      <= '0;
         pix_y      <= '0;
         frame_done <= 1'b0;
      end else begin
         pix_valid  <= 1'b0;
         frame_done <= 1'b0;
         // Owner withdrew its request: release the FIFO without signalling completion.
         if ((state == RRST || state == READ) && owner_lost) begin
            state      <= DONE;
            frame_read <= 1'b1;
            rrst       <= 1'b1;
            oe         <= 1'b1;
            rclk       <= 1'b0;
            grant      <= 2'b00;
            pix_x      <= '0;
            pix_y      <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (new_frame && req != 2'b00) begin
                     state      <= RRST;
                     grant      <= req_pick;
                     last_gnt   <= req_pick[1];
                     frame_read <= 1'b0;
                     rrst       <= 1'b0;
                     oe         <= 1'b1;
                     rclk       <= 1'b1;
                     rst_cnt    <= '0;
                     nx         <= '0;
                     ny         <= '0;
                     last_px    <= 1'b0;
                  end
               end
               RRST: begin
                  if (rst_cnt == RC_LAST) begin
                     state <= READ;
                     rrst  <= 1'b1;
                     oe    <= 1'b0;
                     rclk  <= 1'b1;
                     phase <= 2'd0;
                  end else begin
                     rst_cnt <= rst_cnt + RCW'(1);
                     rclk    <= rst_cnt[0];
                  end
               end
               READ: begin
                  // Final strobe is on the outputs this cycle; finish without another read clock.
                  if (last_px) begin
                     state      <= DONE;
                     frame_done <= 1'b1;
                     frame_read <= 1'b1;
                     oe         <= 1'b1;
                     rclk       <= 1'b0;
                     grant      <= 2'b00;
                  end else begin
                     phase <= phase + 2'd1;
                     case (phase)
                        2'd0: rclk <= 1'b0;
                        2'd1: begin
                           rclk    <= 1'b1;
                           hi_byte <= fifo_d;
                        end
                        2'd2: rclk <= 1'b0;
                        2'd3: begin
                           pixel     <= {hi_byte, fifo_d};
                           pix_valid <= 1'b1;
                           pix_x     <= nx;
                           pix_y     <= ny;
                           last_px   <= at_last;
                           rclk      <= !at_last;
                           if (nx == LAST_X) begin
                              nx <= '0;
                              ny <= ny + 8'd1;
                           end else begin
                              nx <= nx + 9'd1;
                           end
                        end
                     endcase
                  end
               end
               DONE: begin
                  if (!new_frame)
                     state <= IDLE;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_ov_fifo_reader.sv
// Bench for ov_fifo_reader: AL422 read-side model, cycle timeline model of a frame
// read, and directed scenarios for arbitration, abort, reset and writer handshake.
module tb_ov_fifo_reader;
   localparam int H = 4, V = 2, R = 2;
   localparam int N = H * V, R2 = 2 * R, LASTK = R2 + 4 * N + 1;

   logic        clk_25MHz = 1'b0;
   logic        rst_n = 1'b0;
   logic        new_frame = 1'b0;
   logic [1:0]  req = 2'b00;
   logic [7:0]  fifo_d = 8'd0;
   logic        frame_read, rrst, oe, rclk, pix_valid, frame_done;
   logic [1:0]  grant;
   logic [15:0] pixel;
   logic [8:0]  pix_x;
   logic [7:0]  pix_y;

   int vectors = 0, miscompares = 0;

   ov_fifo_reader #(.H_PIX(H), .V_LINES(V), .RRST_CLKS(R)) dut (
      .clk_25MHz(clk_25MHz), .rst_n(rst_n), .new_frame(new_frame),
      .frame_read(frame_read), .rrst(rrst), .oe(oe), .rclk(rclk),
      .fifo_d(fifo_d), .req(req), .grant(grant), .pixel(pixel),
      .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .frame_done(frame_done));

   always #20 clk_25MHz = ~clk_25MHz;

   // AL422 read port: each rclk rise outputs the byte at the read pointer and advances it.
   logic [7:0] rd_ptr = 8'd0;
   logic       rclk_q = 1'b0;
   always @(posedge clk_25MHz) begin
      rclk_q <= rclk;
      if (rclk && !rclk_q) begin
         if (!rrst) rd_ptr <= 8'd0;
         else begin
            fifo_d <= rd_ptr;
            rd_ptr <= rd_ptr + 8'd1;
         end
      end
   end

   // model and monitor state
   int   m_k = 0, m_owner = 0, m_px = 0, m_py = 0;
   logic m_busy = 1'b0, m_wait = 1'b0, m_fd = 1'b0, m_last = 1'b1;
   int   rrst_pulses = 0, fr_low = 0, fd_cnt = 0, fd_cyc = 0, last_strobe_cyc = 0;
   int   fr_falls = 0, fr_rises = 0;
   logic prev_rclk = 1'b0, prev_fr = 1'b1;
   logic [15:0] strobes[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_reset(input string pre);
      chk({pre, " frame_read"}, frame_read, 1);
      chk({pre, " rrst"}, rrst, 1);
      chk({pre, " oe"}, oe, 1);
      chk({pre, " rclk"}, rclk, 0);
      chk({pre, " grant"}, grant, 0);
      chk({pre, " pixel"}, pixel, 0);
      chk({pre, " pix_valid"}, pix_valid, 0);
      chk({pre, " pix_x"}, pix_x, 0);
      chk({pre, " pix_y"}, pix_y, 0);
      chk({pre, " frame_done"}, frame_done, 0);
   endtask

   // Expected outputs derived from the position k within a read's timeline.
   task automatic model_loop();
      int cyc = 0;
      int j, p;
      logic e_fr, e_rrst, e_oe, e_rclk, e_pv;
      logic [1:0]  e_gnt;
      logic [15:0] e_pix;
      forever begin
         @(negedge clk_25MHz);
         cyc++;
         if (!rst_n) begin
            chk_reset("in reset");
            m_busy = 0; m_wait = 0; m_fd = 0; m_last = 1; m_px = 0; m_py = 0;
         end else begin
            e_fr = 1; e_rrst = 1; e_oe = 1; e_rclk = 0; e_pv = 0; e_gnt = 2'b00; e_pix = 16'h0;
            if (m_busy) begin
               e_fr = 0;
               e_gnt = (m_owner == 1) ? 2'b10 : 2'b01;
               if (m_k <= R2) begin
                  e_rrst = 0;
                  e_rclk = (m_k % 2 == 1);
               end else begin
                  j = m_k - R2 - 1;
                  e_oe = 0;
                  e_rclk = (j < 4 * N) && (j % 2 == 0);
                  if (j > 0 && j % 4 == 0) begin
                     p = j / 4 - 1;
                     e_pv = 1;
                     m_px = p % H;
                     m_py = p / H;
                     e_pix = {8'(2 * p), 8'(2 * p + 1)};
                  end
               end
            end
            chk("frame_read", frame_read, e_fr);
            chk("rrst", rrst, e_rrst);
            chk("oe", oe, e_oe);
            chk("rclk", rclk, e_rclk);
            chk("grant", grant, e_gnt);
            chk("pix_valid", pix_valid, e_pv);
            chk("frame_done", frame_done, m_fd);
            chk("pix_x", pix_x, m_px);
            chk("pix_y", pix_y, m_py);
            if (e_pv) chk("pixel", pixel, e_pix);

            if (pix_valid) begin strobes.push_back(pixel); last_strobe_cyc = cyc; end
            if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
            if (!frame_read) fr_low++;
            if (!rrst && rclk && !prev_rclk) rrst_pulses++;
            if (!frame_read && prev_fr) fr_falls++;
            if (frame_read && !prev_fr) fr_rises++;

            m_fd = 0;
            if (m_busy) begin
               if (!req[m_owner]) begin
                  m_busy = 0; m_wait = 1; m_px = 0; m_py = 0;
               end else if (m_k == LASTK) begin
                  m_busy = 0; m_wait = 1; m_fd = 1;
               end else m_k++;
            end else if (m_wait) begin
               if (!new_frame) m_wait = 0;
            end else if (new_frame && req != 2'b00) begin
               m_owner = (req == 2'b11) ? (m_last ? 0 : 1) : (req[1] ? 1 : 0);
               m_last = (m_owner == 1);
               m_busy = 1;
               m_k = 1;
            end
         end
         prev_rclk = rclk;
         prev_fr = frame_read;
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk_25MHz); #1; end
   endtask

   // which: 0 = frame_read, 1 = frame_done, 2 = pix_valid
   task automatic wait_sig(input int which, input logic lvl, input int budget, input string name);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(posedge clk_25MHz); #1;
         case (which)
            0: seen = (frame_read == lvl);
            1: seen = (frame_done == lvl);
            default: seen = (pix_valid == lvl);
         endcase
      end
      chk(name, seen, 1'b1);
   endtask

   logic [15:0] px_tab [8] = '{16'h0001, 16'h0203, 16'h0405, 16'h0607,
                               16'h0809, 16'h0A0B, 16'h0C0D, 16'h0E0F};
   logic [1:0]  gnt_tab [3] = '{2'b01, 2'b10, 2'b01};

   initial begin
      int s_pulses, s_base, s_low, s_falls, s_rises, s_fd;
      logic [1:0] g;
      logic seen;
      fork model_loop(); join_none

      // reset state, then the basic single-consumer frame
      tick(1);
      chk_reset("reset");
      tick(1);
      rst_n = 1'b1;
      tick(2);
      s_pulses = rrst_pulses; s_base = strobes.size(); s_low = fr_low;
      new_frame = 1'b1; req = 2'b01;
      wait_sig(0, 1'b0, 10, "s1 read start");
      chk("s1 grant", grant, 2'b01);
      wait_sig(1, 1'b1, 200, "s1 frame_done");
      tick(1);
      chk("s1 rrst pulses", rrst_pulses - s_pulses, 2);
      chk("s1 strobe count", strobes.size() - s_base, 8);
      for (int i = 0; i < 8; i++)
         if (s_base + i < strobes.size()) chk("s1 pixel", strobes[s_base + i], px_tab[i]);
      chk("s1 done after last strobe", fd_cyc - last_strobe_cyc, 1);
      chk("s1 frame_read low span", fr_low - s_low, LASTK);
      new_frame = 1'b0; req = 2'b00;
      tick(3);

      // round-robin from a fresh reset with both consumers asking
      rst_n = 1'b0; tick(2); rst_n = 1'b1; tick(1);
      req = 2'b11;
      for (int f = 0; f < 3; f++) begin
         new_frame = 1'b1;
         wait_sig(0, 1'b0, 20, "s2 read start");
         g = grant;
         chk("s2 rr grant", g, gnt_tab[f]);
         new_frame = 1'b0;
         wait_sig(1, 1'b1, 200, "s2 frame_done");
         tick(2);
      end
      req = 2'b00;
      tick(2);

      // stale new_frame must not retrigger; then abort by dropping req[0] at pixel 3
      req = 2'b01; new_frame = 1'b1;
      wait_sig(0, 1'b0, 20, "s3 read start");
      wait_sig(1, 1'b1, 200, "s3 frame_done");
      s_falls = fr_falls;
      tick(3);
      new_frame = 1'b0;
      tick(2);
      chk("s3 no restart on stale new_frame", fr_falls - s_falls, 0);
      chk("s3 frame_read idle", frame_read, 1);
      new_frame = 1'b1;
      wait_sig(0, 1'b0, 20, "s3 second read start");
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(posedge clk_25MHz); #1;
         seen = pix_valid && pix_x == 9'd3;
      end
      chk("s3 reached pixel 3", seen, 1'b1);
      req = 2'b00;
      s_fd = fd_cnt;
      tick(1);
      chk("abort frame_read", frame_read, 1);
      chk("abort grant", grant, 2'b00);
      chk("abort pix_x", pix_x, 0);
      chk("abort pix_y", pix_y, 0);
      chk("abort oe", oe, 1);
      tick(3);
      chk("abort no frame_done", fd_cnt - s_fd, 0);
      new_frame = 1'b0;
      tick(2);

      // asynchronous reset during READ, then a normal request
      req = 2'b10; new_frame = 1'b1;
      wait_sig(0, 1'b0, 20, "s4 read start");
      wait_sig(2, 1'b1, 100, "s4 first strobe");
      #2 rst_n = 1'b0;
      #1 chk_reset("async reset");
      tick(2);
      rst_n = 1'b1;
      s_fd = fd_cnt;
      wait_sig(0, 1'b0, 20, "s4 restart");
      chk("s4 grant", grant, 2'b10);
      wait_sig(1, 1'b1, 200, "s4 frame_done");
      tick(1);
      chk("s4 served", fd_cnt - s_fd, 1);
      new_frame = 1'b0; req = 2'b00;
      tick(2);

      // write-side controller: frame written per vsync, new_frame cleared once read starts
      req = 2'b01;
      s_falls = fr_falls; s_rises = fr_rises; s_fd = fd_cnt;
      for (int f = 0; f < 3; f++) begin
         tick(6);
         new_frame = 1'b1;
         wait_sig(0, 1'b0, 20, "s5 read start");
         new_frame = 1'b0;
         wait_sig(0, 1'b1, 200, "s5 read end");
         s_base = fr_falls;
         tick(4);
         chk("s5 no read without new frame", fr_falls - s_base, 0);
      end
      chk("s5 frame_read falls", fr_falls - s_falls, 3);
      chk("s5 frame_read rises", fr_rises - s_rises, 3);
      chk("s5 frames done", fd_cnt - s_fd, 3);
      req = 2'b00;
      tick(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
